btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Front end that turns the five raw push-buttons into clean events for the game-control FSM.
- Per button: 2-FF synchronizer, debouncer and rising-edge one-shot.
- The FSM receives exactly one single-cycle pulse per physical press, so a held button never advances more than one state.
- Sits between the board pins and the game FSM; also exports debounced levels for display/LED use.

Parameters:
- NUM_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized level must stay stable before it is accepted (10 ms at 100 MHz); legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- btn_raw  input  NUM_BTN  raw asynchronous buttons; index 0 center, 1 top, 2 bottom, 3 left, 4 right
- btn_level  output  NUM_BTN  debounced button level
- btn_pulse  output  NUM_BTN  one-cycle pulse on each accepted press
- any_pulse  output  1  OR of btn_pulse, registered in the same cycle

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, reset_n). While reset_n=0 at a clk edge, all of the following clear to 0:
  - sync FFs, counters, btn_level, btn_pulse, any_pulse;
  - all per-channel "armed" bits.
- Synchronizer: s1 <= btn_raw, s2 <= s1. All further logic uses s2 only.
- Debounce, per channel:
  - If s2 == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Glitch rule: any return of s2 to btn_level before the count completes restarts the count from 0. Pulses shorter than DEBOUNCE_CYCLES never change btn_level.
- Latency: raw held high from before edge 0 → btn_level and btn_pulse both rise after edge DEBOUNCE_CYCLES+1.
- Pulse:
  - btn_pulse[i] <= 1 only on the edge where btn_level[i] goes 0→1 and armed[i]=1; otherwise 0.
  - Width is exactly one cycle.
  - A release (1→0) never pulses.
- Armed bit:
  - After reset, armed[i] = 0.
  - armed[i] <= 1 on the first edge where s2[i]=0 out of reset.
  - A button held through reset release therefore raises btn_level after the debounce time but emits no pulse. The next genuine press pulses normally.
- Simultaneous presses: channels are fully independent; several btn_pulse bits may assert in the same cycle. Priority is resolved by the consumer FSM, not here.
- Long hold: one pulse only; no auto-repeat.
- Reset mid-count: the count is discarded and no pulse fires. The channel stays unarmed until the button is seen released.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Decomposition:
- Shared package holds:
  - button index constants BTN_CENTER=0, BTN_TOP=1, BTN_BOTTOM=2, BTN_LEFT=3, BTN_RIGHT=4;
  - NUM_BTN default;
  - DEBOUNCE_CYCLES default for the 100 MHz board clock.
- One sub-module, btn_debounce_ch: single-channel sync + counter + armed + one-shot.
- Top instantiates btn_debounce_ch NUM_BTN times via generate and ORs the pulses into any_pulse (registered).

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Clean press: reset, release reset, btn_raw=00000 for 3 cycles, then btn_raw[0]=1 held 20 cycles → btn_level[0] and btn_pulse[0]=1 after edge 5 (counted from first high sample); btn_pulse[0]=0 after edge 6; any_pulse mirrors it; no further pulses.
- Bounce: btn_raw[1] toggles 1,0,1,1,0 per cycle, then held 1 → no pulse during bouncing; single pulse 5 edges after the final stable rise.
- Release: after clean press of btn_raw[2], drop to 0 and hold → btn_level[2] falls 5 edges later, btn_pulse stays 0 throughout.
- Simultaneous: btn_raw[3] and btn_raw[4] rise on the same edge → btn_pulse=11000 for exactly one cycle, any_pulse=1 for one cycle.
- Held through reset: btn_raw[0]=1 during and after reset → btn_level[0]=1 after 5 edges, btn_pulse[0] never asserts; release 10 cycles then press again → one pulse.
- Reset mid-count: btn_raw[1] rises, reset_n=0 at edge 3, released at edge 4 with button still held → no pulse, all outputs 0 during reset; release/re-press → normal pulse.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button front end: button indices and
// board-level defaults for channel count and debounce time.
package btn_conditioner_pkg;

    // Physical button positions on the board, used as btn_* bit indices.
    typedef enum logic [2:0] {
        BTN_CENTER = 3'd0,
        BTN_TOP    = 3'd1,
        BTN_BOTTOM = 3'd2,
        BTN_LEFT   = 3'd3,
        BTN_RIGHT  = 3'd4
    } btn_idx_e;

    localparam int NUM_BTN_DEF         = 5;
    // 10 ms of stable level at the 100 MHz board clock.
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins, the conditioner and the game FSM.
// master: the conditioner (takes raw pins, drives clean levels/events).
// slave:  the pin side / consumer (drives raw pins, observes events).
interface btn_conditioner_if
    import btn_conditioner_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEF
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               any_pulse;

    modport master (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_pulse
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_pulse
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stability counter, armed bit and
// rising-edge one-shot. pulse_set is the value pulse takes on the next edge,
// exported so the top can register the OR of all channels in the same cycle.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic pulse_set
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             v1;
    logic             v2;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The new level is accepted once s2 has differed from it for the full
    // debounce window; the counter is held at CNT_LAST at most, never wraps.
    assign accept    = (s2 != level) && (cnt == CNT_LAST);
    // Only a 0->1 acceptance on an armed channel is a press event.
    assign pulse_set = accept && s2 && armed;

    // Synchronize, debounce, arm and generate the one-shot.
    // NOTE: reset is sampled on the clock edge (synchronous), so every
    // register here, including the synchronizer, clears only on a clk edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so s2 samples the old s1 and
            // every decision below sees this cycle's register values.
            s1 <= raw;
            s2 <= s1;
            // v1/v2 mark that s1/s2 hold real pin samples; right after reset
            // s2 reads a cleared 0, which must not count as a release.
            v1 <= 1'b1;
            v2 <= v1;
            if (v2 && !s2) begin
                armed <= 1'b1;
            end
            if (s2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            pulse <= pulse_set;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Top of the button front end: NUM_BTN independent debounce channels plus a
// registered "any button pressed" event aligned with btn_pulse.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    btn_conditioner_if.master   bus
);

    logic [NUM_BTN-1:0] pulse_set;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (bus.btn_raw[i]),
            .level     (bus.btn_level[i]),
            .pulse     (bus.btn_pulse[i]),
            .pulse_set (pulse_set[i])
        );
    end

    // Register the OR of next-cycle pulses so any_pulse lines up with btn_pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.any_pulse <= 1'b0;
        end else begin
            bus.any_pulse <= |pulse_set;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4. Inputs change
// 1 ns after a rising edge; outputs are checked at that same point, so each
// tick() means "one more edge has happened". Expected windows are written in
// edges counted from the first edge that samples the new raw value (E0): a
// press is accepted after E5.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int NB = 5;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    btn_conditioner_if #(.NUM_BTN(NB)) bus ();

    btn_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all three outputs; any_pulse must equal OR of expected pulses.
    task automatic check_outs(input string tag, input logic [NB-1:0] lvl, input logic [NB-1:0] pls);
        check({tag, ".level"}, 8'(bus.btn_level), 8'(lvl));
        check({tag, ".pulse"}, 8'(bus.btn_pulse), 8'(pls));
        check({tag, ".any"},   8'(bus.any_pulse), 8'(|pls));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.btn_raw = '0;

        // Reset state.
        idle(2);
        check_outs("reset", 5'b00000, 5'b00000);
        reset_n = 1'b1;
        idle(3);

        // Clean press on center, held 20 edges: one pulse after E5.
        bus.btn_raw[BTN_CENTER] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_outs($sformatf("press_e%0d", k),
                       (k >= 5) ? 5'b00001 : 5'b00000,
                       (k == 5) ? 5'b00001 : 5'b00000);
        end
        bus.btn_raw[BTN_CENTER] = 1'b0;
        idle(8);
        check_outs("press_released", 5'b00000, 5'b00000);

        // Bounce on top: 1,0,1,1,0 then steady 1 from B5 -> pulse after B10.
        begin
            logic [4:0] bounce;
            bounce = 5'b01101;
            for (int k = 0; k < 16; k++) begin
                bus.btn_raw[BTN_TOP] = (k < 5) ? bounce[k] : 1'b1;
                tick();
                check_outs($sformatf("bounce_b%0d", k),
                           (k >= 10) ? 5'b00010 : 5'b00000,
                           (k == 10) ? 5'b00010 : 5'b00000);
            end
        end
        bus.btn_raw[BTN_TOP] = 1'b0;
        idle(8);

        // Press bottom, then release: level falls after E5, no pulse.
        bus.btn_raw[BTN_BOTTOM] = 1'b1;
        idle(5);
        tick();
        check_outs("rel_press", 5'b00100, 5'b00100);
        idle(3);
        bus.btn_raw[BTN_BOTTOM] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_outs($sformatf("release_e%0d", k),
                       (k < 5) ? 5'b00100 : 5'b00000, 5'b00000);
        end

        // Left and right together: one shared cycle of pulses.
        bus.btn_raw[BTN_LEFT]  = 1'b1;
        bus.btn_raw[BTN_RIGHT] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_outs($sformatf("simul_e%0d", k),
                       (k >= 5) ? 5'b11000 : 5'b00000,
                       (k == 5) ? 5'b11000 : 5'b00000);
        end
        bus.btn_raw = '0;
        idle(8);

        // Center held through reset: level rises, never pulses.
        bus.btn_raw[BTN_CENTER] = 1'b1;
        reset_n = 1'b0;
        idle(2);
        check_outs("hold_in_reset", 5'b00000, 5'b00000);
        reset_n = 1'b1;
        // Edge R1 is the first to sample the held pin -> level after R6.
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_outs($sformatf("hold_r%0d", k),
                       (k >= 6) ? 5'b00001 : 5'b00000, 5'b00000);
        end
        bus.btn_raw[BTN_CENTER] = 1'b0;
        idle(10);
        check_outs("hold_released", 5'b00000, 5'b00000);
        bus.btn_raw[BTN_CENTER] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs($sformatf("hold_repress_e%0d", k),
                       (k >= 5) ? 5'b00001 : 5'b00000,
                       (k == 5) ? 5'b00001 : 5'b00000);
        end
        bus.btn_raw[BTN_CENTER] = 1'b0;
        idle(8);

        // Top rises, reset sampled at M3 only; button stays held.
        bus.btn_raw[BTN_TOP] = 1'b1;
        idle(3);
        reset_n = 1'b0;
        tick();
        check_outs("midcnt_reset", 5'b00000, 5'b00000);
        reset_n = 1'b1;
        // M4 is the first post-reset sample -> level after M9, no pulse.
        for (int k = 4; k <= 14; k++) begin
            tick();
            check_outs($sformatf("midcnt_m%0d", k),
                       (k >= 9) ? 5'b00010 : 5'b00000, 5'b00000);
        end
        bus.btn_raw[BTN_TOP] = 1'b0;
        idle(10);
        bus.btn_raw[BTN_TOP] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_outs($sformatf("midcnt_repress_e%0d", k),
                       (k >= 5) ? 5'b00010 : 5'b00000,
                       (k == 5) ? 5'b00010 : 5'b00000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
